// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle MULT/DIV unit owning the HI/LO registers
// Optional MADD/MSUB accumulate ops are built only when MULDIV_ACCUM_EN is defined.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic [1:0]       hlWrite,
    input  logic [WIDTH-1:0] dinHi,
    input  logic [WIDTH-1:0] dinLo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] doutHi,
    output logic [WIDTH-1:0] doutLo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [1:0]         kind;
    logic [WIDTH-1:0]   mag_a, mag_b, rem;
    logic               neg_res, neg_rem;
    logic [2*WIDTH-1:0] acc;
    logic               accept, commit, legal, is_div;

    logic               neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt, quo, rmd, a_orig;
    logic [2*WIDTH-1:0] prod, res;

`ifdef MULDIV_ACCUM_EN
    assign legal = 1'b1;
`else
    assign legal = ~op[2];
`endif

    assign busy   = (state != IDLE);
    assign is_div = (kind == 2'b01);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: if (start && legal && !cancel) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cancel)
                    state_nxt = IDLE;
                else if (cnt == LAST)
                    state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
                commit    = ~cancel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Signed ops (even op codes) iterate on magnitudes and fix signs at the end
    always_comb begin
        neg_a_in = ~op[0] & a[WIDTH-1];
        neg_b_in = ~op[0] & b[WIDTH-1];
        mag_a_in = neg_a_in ? -a : a;
        mag_b_in = neg_b_in ? -b : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        // the partial remainder stays below the divisor, so the low WIDTH bits suffice
        rem_nxt   = div_ge ? (div_shift[WIDTH-1:0] - mag_b) : div_shift[WIDTH-1:0];
    end

    always_comb begin
        prod   = neg_res ? -acc : acc;
        quo    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd    = neg_rem ? -rem : rem;
        a_orig = neg_rem ? -mag_a : mag_a;
        if (is_div) begin
            if (mag_b == '0)
                res = {a_orig, {WIDTH{1'b1}}};
            else
                res = {rmd, quo};
        end else if (kind[1]) begin
`ifdef MULDIV_ACCUM_EN
            res = kind[0] ? ({doutHi, doutLo} - prod) : ({doutHi, doutLo} + prod);
`else
            res = prod;
`endif
        end else begin
            res = prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= commit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            kind    <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            rem     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
        end else if (accept) begin
            kind    <= op[2:1];
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
            neg_res <= neg_a_in ^ neg_b_in;
            neg_rem <= neg_a_in;
            cnt     <= '0;
            rem     <= '0;
            acc     <= {{WIDTH{1'b0}}, (op[2:1] == 2'b01) ? mag_a_in : mag_b_in};
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                rem <= rem_nxt;
                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

    // A commit on the same edge overrides any direct write
    always_ff @(posedge clk) begin
        if (rst) begin
            doutHi <= '0;
            doutLo <= '0;
        end else if (commit) begin
            {doutHi, doutLo} <= res;
        end else begin
            if (hlWrite[1]) doutHi <= dinHi;
            if (hlWrite[0]) doutLo <= dinLo;
        end
    end

endmodule
